// File: rtl/axi_master_pkg.sv
// Shared types and AXI constants for the single-outstanding AXI master.
// Bus widths follow the AXI_define.svh values used across the codebase.
package axi_master_pkg;

  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;
  localparam int AXI_LEN_BITS  = 4;

  localparam logic [2:0]              AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0]              AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]              AXI_RESP_OKAY  = 2'b00;
  localparam logic [AXI_LEN_BITS-1:0] AXI_LEN_SINGLE = 4'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_W    = 3'd4,
    S_B    = 3'd5,
    S_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/axi_master_dm.sv
// Bridges a stalling CPU port to AXI, one single-beat transaction at a time.
// Define AXI_MASTER_DM_RESP_CHECK_EN to get a sticky error flag on non-OKAY responses.
module axi_master_dm
  import axi_master_pkg::*;
#(
  parameter logic [AXI_ID_BITS-1:0] MASTER_ID = 4'd1
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     cpu_req,
  input  logic [AXI_STRB_BITS-1:0] cpu_web,
  input  logic [AXI_ADDR_BITS-1:0] cpu_addr,
  input  logic [AXI_DATA_BITS-1:0] cpu_wdata,
  output logic [AXI_DATA_BITS-1:0] cpu_rdata,
  output logic                     cpu_stall,
  output logic                     cpu_done,
  output logic [AXI_ID_BITS-1:0]   AWID,
  output logic [AXI_ADDR_BITS-1:0] AWADDR,
  output logic [AXI_LEN_BITS-1:0]  AWLEN,
  output logic [2:0]               AWSIZE,
  output logic [1:0]               AWBURST,
  output logic                     AWVALID,
  input  logic                     AWREADY,
  output logic [AXI_DATA_BITS-1:0] WDATA,
  output logic [AXI_STRB_BITS-1:0] WSTRB,
  output logic                     WLAST,
  output logic                     WVALID,
  input  logic                     WREADY,
  input  logic [AXI_ID_BITS-1:0]   BID,
  input  logic [1:0]               BRESP,
  input  logic                     BVALID,
  output logic                     BREADY,
  output logic [AXI_ID_BITS-1:0]   ARID,
  output logic [AXI_ADDR_BITS-1:0] ARADDR,
  output logic [AXI_LEN_BITS-1:0]  ARLEN,
  output logic [2:0]               ARSIZE,
  output logic [1:0]               ARBURST,
  output logic                     ARVALID,
  input  logic                     ARREADY,
  input  logic [AXI_ID_BITS-1:0]   RID,
  input  logic [AXI_DATA_BITS-1:0] RDATA,
  input  logic [1:0]               RRESP,
  input  logic                     RLAST,
  input  logic                     RVALID,
  output logic                     RREADY,
  output logic                     resp_err,
  output state_t                   dbg_state_o
);

  state_t                   state_q, state_d;
  logic [AXI_ADDR_BITS-1:0] addr_q, addr_d;
  logic [AXI_DATA_BITS-1:0] wdata_q, wdata_d;
  logic [AXI_STRB_BITS-1:0] wstrb_q, wstrb_d;
  logic [AXI_DATA_BITS-1:0] rdata_q, rdata_d;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

  // Handshake exits use only READY/VALID from the slave; our own VALIDs are pure state decodes.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          wstrb_d = ~cpu_web;
          state_d = (cpu_web == 4'hF) ? S_AR : S_AW;
        end
      end
      S_AR:   if (ARREADY) state_d = S_R;
      S_R: begin
        if (RVALID) begin
          rdata_d = RDATA;
          state_d = S_DONE;
        end
      end
      S_AW:   if (AWREADY) state_d = S_W;
      S_W:    if (WREADY) state_d = S_B;
      S_B:    if (BVALID) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ARVALID = (state_q == S_AR);
  assign RREADY  = (state_q == S_R);
  assign AWVALID = (state_q == S_AW);
  assign WVALID  = (state_q == S_W);
  assign WLAST   = (state_q == S_W);
  assign BREADY  = (state_q == S_B);

  assign cpu_done  = (state_q == S_DONE);
  assign cpu_stall = cpu_req && (state_q != S_DONE);
  assign cpu_rdata = rdata_q;

  assign ARID    = MASTER_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = AXI_LEN_SINGLE;
  assign ARSIZE  = AXI_SIZE_WORD;
  assign ARBURST = AXI_BURST_INCR;
  assign AWID    = MASTER_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = AXI_LEN_SINGLE;
  assign AWSIZE  = AXI_SIZE_WORD;
  assign AWBURST = AXI_BURST_INCR;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;

  assign dbg_state_o = state_q;

`ifdef AXI_MASTER_DM_RESP_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((state_q == S_R && RVALID && RRESP != AXI_RESP_OKAY) ||
        (state_q == S_B && BVALID && BRESP != AXI_RESP_OKAY))
      err_d = 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign resp_err = err_q;

  // IDs are not matched and single-beat reads make RLAST redundant.
  logic unused_inputs;
  assign unused_inputs = ^{BID, RID, RLAST};
`else
  assign resp_err = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{BID, RID, RLAST, RRESP, BRESP};
`endif

endmodule

// File: doc/axi_master_dm.md
AXI_MASTER_DM -- requirements
Module: axi_master_dm

Interface
REQ-001 Parameter MASTER_ID, default 4'd1, driven on ARID and AWID.
REQ-002 ACLK  input  1  clock; all state updates on rising edge.
REQ-003 ARESETn  input  1  reset, asynchronous, active-low.
REQ-004 cpu_req  input  1  access request; held by CPU until cpu_done.
REQ-005 cpu_web  input  4  byte write enables, active-low; 4'b1111 = read.
REQ-006 cpu_addr  input  32  byte address.
REQ-007 cpu_wdata  input  32  write data.
REQ-008 cpu_rdata  output  32  read data, valid from cpu_done of a read until the next read completes.
REQ-009 cpu_stall  output  1  high while cpu_req is pending and not completing.
REQ-010 cpu_done  output  1  single-cycle completion pulse.
REQ-011 AWID out 4, AWADDR out 32, AWLEN out 4, AWSIZE out 3, AWBURST out 2, AWVALID out 1, AWREADY in 1.
REQ-012 WDATA out 32, WSTRB out 4, WLAST out 1, WVALID out 1, WREADY in 1.
REQ-013 BID in 4, BRESP in 2, BVALID in 1, BREADY out 1.
REQ-014 ARID out 4, ARADDR out 32, ARLEN out 4, ARSIZE out 3, ARBURST out 2, ARVALID out 1, ARREADY in 1.
REQ-015 RID in 4, RDATA in 32, RRESP in 2, RLAST in 1, RVALID in 1, RREADY out 1.
REQ-016 resp_err  output  1  sticky response-error flag (see Configuration).

Function
REQ-017 FSM states: IDLE, AR, R, AW, W, B, DONE; 3-bit encoding.
REQ-018 IDLE: cpu_req && cpu_web==4'hF -> AR; cpu_req && cpu_web!=4'hF -> AW; transition latches addr, wdata, and WSTRB = ~cpu_web.
REQ-019 AR: ARVALID=1; on ARVALID&&ARREADY -> R; ARVALID/ARADDR stable until handshake.
REQ-020 R: RREADY=1; on RVALID -> capture RDATA into cpu_rdata, -> DONE.
REQ-021 AW: AWVALID=1; on handshake -> W. W valid only after AW handshake, never concurrently.
REQ-022 W: WVALID=1, WLAST=1, WDATA/WSTRB from latches; on WREADY -> B.
REQ-023 B: BREADY=1; on BVALID -> DONE.
REQ-024 DONE: cpu_done=1 for exactly one cycle; -> IDLE unconditionally; no request accepted in DONE.
REQ-025 cpu_stall = cpu_req && state!=DONE (combinational).
REQ-026 Constants: AxLEN=4'd0, AxSIZE=3'b010, AxBURST=2'b01 (INCR); AxADDR driven from address latch in all states.
REQ-027 Latency, zero-wait responder: read cpu_done 3 cycles after cpu_req sampled in IDLE; write 4 cycles.
REQ-028 One outstanding transaction; BID/RID not compared; RLAST ignored.
REQ-029 cpu_req dropped mid-transaction: transaction completes per AXI, cpu_done still pulses.
REQ-030 VALID never depends combinationally on the matching READY.

Reset
REQ-031 While ARESETn=0: state IDLE; all VALID/READY outputs 0; cpu_done 0; cpu_rdata, address/data/strobe latches 0; resp_err 0.
REQ-032 Reset mid-transaction aborts it; no resumption after release.

Configuration
REQ-033 Macro AXI_MASTER_DM_RESP_CHECK_EN defined: resp_err set on R handshake with RRESP!=2'b00 or B handshake with BRESP!=2'b00; sticky until reset.
REQ-034 Macro undefined: resp_err tied 0, no flag register; FSM behaviour unchanged.

Structure
REQ-035 Package axi_master_pkg holds: state enum, AXI_SIZE_WORD=3'b010, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, AXI_LEN_SINGLE=4'd0; bus widths from AXI_define.svh.
REQ-036 Single module, no sub-module.

Verification
REQ-037 Read, zero-wait: addr 32'h0000_0010, RDATA 32'hDEAD_BEEF -> ARADDR 32'h10, cpu_done at cycle 3, cpu_rdata 32'hDEAD_BEEF.
REQ-038 Write: cpu_web 4'b1100, wdata 32'h1234_5678 -> AWVALID then WVALID, WSTRB 4'b0011, WLAST 1, cpu_done cycle 4.
REQ-039 ARREADY held low 5 cycles -> ARVALID/ARADDR stable all 5 cycles, cpu_stall 1 throughout.
REQ-040 AWREADY delayed 3 cycles -> WVALID stays 0 until cycle after AW handshake.
REQ-041 ARESETn low while in W -> WVALID 0 immediately, state IDLE, no cpu_done.
REQ-042 BRESP=2'b11 with macro -> resp_err 1 and stays 1; without macro -> resp_err 0.
